// File: rtl/seq_alu.sv
// Multi-cycle ALU: single-cycle ops, latency 1; iterative MULU/DIVU, latency WIDTH+1.
// `start` is ignored while busy. DIVU is built only when SEQ_ALU_DIV_EN is defined.
module seq_alu #(
   parameter int WIDTH = 32,
   localparam int CW = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result_lo,
   output logic [WIDTH-1:0] result_hi,
   output logic             zero,
   output logic             err
);

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_AND  = 4'd2;
   localparam logic [3:0] OP_OR   = 4'd3;
   localparam logic [3:0] OP_XOR  = 4'd4;
   localparam logic [3:0] OP_NOR  = 4'd5;
   localparam logic [3:0] OP_SLT  = 4'd6;
   localparam logic [3:0] OP_SLTU = 4'd7;
   localparam logic [3:0] OP_MULU = 4'd8;
`ifdef SEQ_ALU_DIV_EN
   localparam logic [3:0] OP_DIVU = 4'd9;
`endif

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t             state_q, state_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               err_q, err_d;
   logic               zero_q, zero_d;
   logic               eq_q, eq_d;
   logic [WIDTH-1:0]   res_lo_q, res_lo_d;
   logic [WIDTH-1:0]   res_hi_q, res_hi_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [WIDTH-1:0]   opnd_q, opnd_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;

   logic [WIDTH-1:0]   sc_lo, sc_hi;
   logic               sc_err;
   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] acc_step;

`ifdef SEQ_ALU_DIV_EN
   logic               is_div_q, is_div_d;
   logic [WIDTH-1:0]   quo_q, quo_d;
   logic [WIDTH-1:0]   rem_q, rem_d;
   logic [WIDTH:0]     rem_sh;
   logic               rem_ge;
   logic [WIDTH-1:0]   quo_step, rem_step;

   // Restoring step: remainder stays below the divisor, so WIDTH bits hold it between steps.
   always_comb begin
      rem_sh   = {rem_q, quo_q[WIDTH-1]};
      rem_ge   = (rem_sh >= {1'b0, opnd_q});
      rem_step = rem_ge ? WIDTH'(rem_sh - {1'b0, opnd_q}) : WIDTH'(rem_sh);
      quo_step = {quo_q[WIDTH-2:0], rem_ge};
   end
`endif

   always_comb begin
      mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
      acc_step = {mul_sum, acc_q[WIDTH-1:1]};
   end

   always_comb begin
      sc_lo  = '0;
      sc_hi  = '0;
      sc_err = 1'b0;
      case (op)
         OP_ADD:  sc_lo = a + b;
         OP_SUB:  sc_lo = a - b;
         OP_AND:  sc_lo = a & b;
         OP_OR:   sc_lo = a | b;
         OP_XOR:  sc_lo = a ^ b;
         OP_NOR:  sc_lo = ~(a | b);
         OP_SLT:  sc_lo = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
         OP_SLTU: sc_lo = {{(WIDTH-1){1'b0}}, (a < b)};
`ifdef SEQ_ALU_DIV_EN
         // Only reached with b == 0; nonzero divisors iterate instead.
         OP_DIVU: begin
            sc_lo  = '1;
            sc_hi  = a;
            sc_err = 1'b1;
         end
`endif
         default: sc_err = 1'b1;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      err_d    = err_q;
      zero_d   = zero_q;
      eq_d     = eq_q;
      res_lo_d = res_lo_q;
      res_hi_d = res_hi_q;
      cnt_d    = cnt_q;
      opnd_d   = opnd_q;
      acc_d    = acc_q;
`ifdef SEQ_ALU_DIV_EN
      is_div_d = is_div_q;
      quo_d    = quo_q;
      rem_d    = rem_q;
`endif
      case (state_q)
         RUN: begin
            cnt_d = cnt_q - CW'(1);
`ifdef SEQ_ALU_DIV_EN
            if (is_div_q) begin
               quo_d = quo_step;
               rem_d = rem_step;
            end else begin
               acc_d = acc_step;
            end
`else
            acc_d = acc_step;
`endif
            if (cnt_q == CW'(1)) begin
               state_d  = DONE;
               busy_d   = 1'b0;
               done_d   = 1'b1;
               err_d    = 1'b0;
               zero_d   = eq_q;
               res_lo_d = acc_step[WIDTH-1:0];
               res_hi_d = acc_step[2*WIDTH-1:WIDTH];
`ifdef SEQ_ALU_DIV_EN
               if (is_div_q) begin
                  res_lo_d = quo_step;
                  res_hi_d = rem_step;
               end
`endif
            end
         end
         default: begin
            if (state_q == DONE) state_d = IDLE;
            if (start) begin
               if (op == OP_MULU) begin
                  acc_d   = {{WIDTH{1'b0}}, a};
                  opnd_d  = b;
                  eq_d    = (a == b);
                  cnt_d   = CW'(WIDTH);
                  busy_d  = 1'b1;
                  state_d = RUN;
`ifdef SEQ_ALU_DIV_EN
                  is_div_d = 1'b0;
               end else if (op == OP_DIVU && b != '0) begin
                  quo_d    = a;
                  rem_d    = '0;
                  opnd_d   = b;
                  eq_d     = (a == b);
                  cnt_d    = CW'(WIDTH);
                  busy_d   = 1'b1;
                  is_div_d = 1'b1;
                  state_d  = RUN;
`endif
               end else begin
                  res_lo_d = sc_lo;
                  res_hi_d = sc_hi;
                  err_d    = sc_err;
                  zero_d   = (a == b);
                  done_d   = 1'b1;
                  state_d  = DONE;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         zero_q   <= 1'b0;
         eq_q     <= 1'b0;
         res_lo_q <= '0;
         res_hi_q <= '0;
         cnt_q    <= '0;
         opnd_q   <= '0;
         acc_q    <= '0;
`ifdef SEQ_ALU_DIV_EN
         is_div_q <= 1'b0;
         quo_q    <= '0;
         rem_q    <= '0;
`endif
      end else begin
         state_q  <= state_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         err_q    <= err_d;
         zero_q   <= zero_d;
         eq_q     <= eq_d;
         res_lo_q <= res_lo_d;
         res_hi_q <= res_hi_d;
         cnt_q    <= cnt_d;
         opnd_q   <= opnd_d;
         acc_q    <= acc_d;
`ifdef SEQ_ALU_DIV_EN
         is_div_q <= is_div_d;
         quo_q    <= quo_d;
         rem_q    <= rem_d;
`endif
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign err       = err_q;
   assign zero      = zero_q;
   assign result_lo = res_lo_q;
   assign result_hi = res_hi_q;

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu (WIDTH=32); expectations follow SEQ_ALU_DIV_EN if defined.
module tb_seq_alu;
   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst, start;
   logic [3:0]   op;
   logic [W-1:0] a, b;
   logic         busy, done, zero, err;
   logic [W-1:0] result_lo, result_hi;

   int   compared = 0;
   int   mismatched = 0;
   int   done_cnt = 0;
   int   lat, busy_cyc, d0;
   logic overlap = 1'b0;

   seq_alu #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
      .busy(busy), .done(done), .result_lo(result_lo), .result_hi(result_hi),
      .zero(zero), .err(err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (done === 1'b1) done_cnt++;
      if (done === 1'b1 && busy === 1'b1) overlap = 1'b1;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic run_op(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
      @(negedge clk);
      start = 1'b1; op = o; a = x; b = y;
      @(posedge clk); #1;
      start = 1'b0; lat = 1; busy_cyc = 0;
      while (done !== 1'b1 && lat < 200) begin
         if (busy === 1'b1) busy_cyc++;
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic check_res(input string tag, input int exp_lat, input logic [W-1:0] lo,
                            input logic [W-1:0] hi, input logic e, input logic z);
      check({tag, "_lat"}, lat, exp_lat);
      check({tag, "_lo"}, result_lo, lo);
      check({tag, "_hi"}, result_hi, hi);
      check({tag, "_err"}, err, e);
      check({tag, "_zero"}, zero, z);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; op = 4'd0; a = '0; b = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_lo", result_lo, 0);
      check("rst_hi", result_hi, 0);
      check("rst_err", err, 0);
      check("rst_zero", zero, 0);
      @(negedge clk) rst = 1'b0;

      run_op(4'd0, 32'hFFFF_FFFF, 32'h1);
      check_res("add_wrap", 1, 32'h0, 32'h0, 1'b0, 1'b0);
      @(posedge clk); #1;
      check("add_done_pulse", done, 0);
      check("add_hold_lo", result_lo, 0);

      // SLT then SLTU back-to-back with start held through the DONE cycle
      @(negedge clk);
      start = 1'b1; op = 4'd6; a = 32'hFFFF_FFFE; b = 32'h1;
      @(posedge clk); #1;
      check("slt_done", done, 1);
      check("slt_lo", result_lo, 1);
      op = 4'd7;
      @(posedge clk); #1;
      check("sltu_done", done, 1);
      check("sltu_lo", result_lo, 0);
      start = 1'b0;

      run_op(4'd1, 32'd5, 32'd7);
      check_res("sub", 1, 32'hFFFF_FFFE, 32'h0, 1'b0, 1'b0);
      run_op(4'd2, 32'hF0F0_F0F0, 32'hFF00_FF00);
      check("and_lo", result_lo, 32'hF000_F000);
      run_op(4'd3, 32'hF0F0_F0F0, 32'hFF00_FF00);
      check("or_lo", result_lo, 32'hFFF0_FFF0);
      run_op(4'd4, 32'h1234_5678, 32'h1234_5678);
      check_res("xor_eq", 1, 32'h0, 32'h0, 1'b0, 1'b1);
      run_op(4'd5, 32'h0F0F_0F0F, 32'hF0F0_0000);
      check("nor_lo", result_lo, 32'h0000_F0F0);

      // MULU max*max with an extra start injected mid-run
      @(negedge clk);
      start = 1'b1; op = 4'd8; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
      @(posedge clk); #1;
      start = 1'b0; lat = 1; busy_cyc = 0; d0 = done_cnt;
      while (done !== 1'b1 && lat < 200) begin
         if (busy === 1'b1) busy_cyc++;
         if (lat == 10) begin
            start = 1'b1; op = 4'd0; a = 32'd1; b = 32'd2;
         end else begin
            start = 1'b0;
         end
         @(posedge clk); #1;
         lat++;
      end
      start = 1'b0;
      check_res("mulu_max", 33, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0, 1'b1);
      check("mulu_busy_cycles", busy_cyc, 32);
      @(posedge clk); #1;
      check("mulu_single_done", done_cnt - d0, 1);
      check("mulu_hold_lo", result_lo, 32'h1);

      run_op(4'd8, 32'h0001_0000, 32'h0001_0000);
      check_res("mulu_carry", 33, 32'h0, 32'h1, 1'b0, 1'b1);
      run_op(4'd8, 32'd6, 32'd7);
      check_res("mulu_small", 33, 32'd42, 32'h0, 1'b0, 1'b0);

`ifdef SEQ_ALU_DIV_EN
      run_op(4'd9, 32'd100, 32'd7);
      check_res("divu", 33, 32'd14, 32'd2, 1'b0, 1'b0);
      check("divu_busy_cycles", busy_cyc, 32);
      run_op(4'd9, 32'd5, 32'd0);
      check_res("divu_by_zero", 1, 32'hFFFF_FFFF, 32'd5, 1'b1, 1'b0);
`else
      run_op(4'd9, 32'd100, 32'd7);
      check_res("divu_disabled", 1, 32'h0, 32'h0, 1'b1, 1'b0);
`endif

      run_op(4'd8, 32'd3, 32'd5);
      run_op(4'd12, 32'd9, 32'd9);
      check_res("illegal_12", 1, 32'h0, 32'h0, 1'b1, 1'b1);

      // Reset at iteration 10 of a MULU discards the run
      @(negedge clk);
      start = 1'b1; op = 4'd8; a = 32'hFFFF_FFFF; b = 32'd3;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      check("mid_run_busy", busy, 1);
      @(negedge clk) rst = 1'b1;
      @(posedge clk); #1;
      check("midrst_busy", busy, 0);
      check("midrst_done", done, 0);
      check("midrst_lo", result_lo, 0);
      check("midrst_hi", result_hi, 0);
      check("midrst_err", err, 0);
      check("midrst_zero", zero, 0);
      @(negedge clk) rst = 1'b0;
      d0 = done_cnt;
      repeat (40) @(posedge clk);
      #1;
      check("midrst_no_done", done_cnt - d0, 0);
      check("midrst_idle_busy", busy, 0);
      run_op(4'd0, 32'd2, 32'd3);
      check_res("add_after_rst", 1, 32'd5, 32'h0, 1'b0, 1'b0);

      check("done_busy_overlap", overlap, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
